instruction_packer: RTL and testbench

- Writer-side counterpart to the fetch-side parcel aligner. It accepts a stream of RVC (16-bit) and 32-bit instructions and packs them into word-aligned 32-bit memory writes with byte strobes.
- 32-bit instructions that straddle a word boundary are split across two writes.
- Sits between the debug/program-loader path and instruction memory, so the words it writes are the exact layout the fetch aligner later consumes.

---
 rtl/instruction_packer_if.sv | 31 +++
 rtl/instruction_packer.sv | 165 ++++++++++++++++
 tb/tb_instruction_packer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_packer_if.sv
// Bus bundle for instruction_packer: start/flush controls, instruction stream in,
// word-aligned strobed memory writes out, plus status.
interface instruction_packer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  i_start_valid;
  logic [ADDR_WIDTH-1:0] i_start_addr;
  logic                  i_instr_valid;
  logic                  o_instr_ready;
  logic [31:0]           i_instr;
  logic                  i_flush;
  logic                  o_wr_valid;
  logic                  i_wr_ready;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [31:0]           o_wr_data;
  logic [3:0]            o_wr_strb;
  logic [ADDR_WIDTH-1:0] o_next_pc;
  logic                  o_busy;

  // Packer side.
  modport master (
    input  i_start_valid, i_start_addr, i_instr_valid, i_instr, i_flush, i_wr_ready,
    output o_instr_ready, o_wr_valid, o_wr_addr, o_wr_data, o_wr_strb, o_next_pc, o_busy
  );

  // Loader / memory side.
  modport slave (
    output i_start_valid, i_start_addr, i_instr_valid, i_instr, i_flush, i_wr_ready,
    input  o_instr_ready, o_wr_valid, o_wr_addr, o_wr_data, o_wr_strb, o_next_pc, o_busy
  );
endinterface

// File: rtl/instruction_packer.sv
// Packs a stream of RVC and 32-bit instructions into word-aligned strobed 32-bit writes.
// Define INSTR_PACKER_NOP_PAD_EN to pad a flushed half-word with c.nop and a full strobe.
module instruction_packer #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  instruction_packer_if.master        bus
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

`ifdef INSTR_PACKER_NOP_PAD_EN
  localparam logic [15:0] PadHalf = 16'h0001;
  localparam logic [3:0]  PadStrb = 4'b1111;
`else
  localparam logic [15:0] PadHalf = 16'h0000;
  localparam logic [3:0]  PadStrb = 4'b0011;
`endif

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [15:0]           pend_data_q, pend_data_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [3:0]            wr_strb_q, wr_strb_d;

  logic                  out_free;
  logic                  flush_req;
  logic                  instr_ready;
  logic                  instr_fire;
  logic                  is_rvc;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [15:0]           pend_lo;
  logic [3:0]            pend_strb;

  // The output register can take a new write if empty or being drained this cycle.
  assign out_free    = !wr_valid_q || bus.i_wr_ready;
  // A flush pulse is remembered until its pad write has been loaded.
  assign flush_req   = bus.i_flush || flush_pend_q;
  assign instr_ready = (state_q == StActive) && !flush_req && out_free;
  assign instr_fire  = instr_ready && bus.i_instr_valid;
  assign is_rvc      = (bus.i_instr[1:0] != 2'b11);
  assign word_addr   = {cur_q[ADDR_WIDTH-1:2], 2'b00};
  assign pend_lo     = pend_valid_q ? pend_data_q : 16'h0000;
  assign pend_strb   = pend_valid_q ? 4'b1111 : 4'b1100;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    flush_pend_d = flush_pend_q;
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_strb_d    = wr_strb_q;

    if (wr_valid_q && bus.i_wr_ready) begin
      wr_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        flush_pend_d = 1'b0;
        if (bus.i_start_valid) begin
          cur_d        = bus.i_start_addr & ~ADDR_WIDTH'(1);
          pend_valid_d = 1'b0;
          state_d      = StActive;
        end
      end

      StActive: begin
        if (flush_req) begin
          if (!pend_valid_q) begin
            flush_pend_d = 1'b0;
            state_d      = StIdle;
          end else if (out_free) begin
            wr_valid_d   = 1'b1;
            wr_addr_d    = word_addr;
            wr_data_d    = {PadHalf, pend_data_q};
            wr_strb_d    = PadStrb;
            pend_valid_d = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = StIdle;
          end else begin
            flush_pend_d = 1'b1;
          end
        end else if (instr_fire) begin
          if (!cur_q[1]) begin
            if (is_rvc) begin
              pend_data_d  = bus.i_instr[15:0];
              pend_valid_d = 1'b1;
              cur_d        = cur_q + ADDR_WIDTH'(2);
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = word_addr;
              wr_data_d  = bus.i_instr;
              wr_strb_d  = 4'b1111;
              cur_d      = cur_q + ADDR_WIDTH'(4);
            end
          end else begin
            // Upper half of the current word completes it; a 32-bit instruction's
            // upper parcel becomes the low half of the next word.
            wr_valid_d = 1'b1;
            wr_addr_d  = word_addr;
            wr_data_d  = {bus.i_instr[15:0], pend_lo};
            wr_strb_d  = pend_strb;
            if (is_rvc) begin
              pend_valid_d = 1'b0;
              cur_d        = cur_q + ADDR_WIDTH'(2);
            end else begin
              pend_data_d  = bus.i_instr[31:16];
              pend_valid_d = 1'b1;
              cur_d        = cur_q + ADDR_WIDTH'(4);
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      flush_pend_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      flush_pend_q <= flush_pend_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_strb_q    <= wr_strb_d;
    end
  end

  assign bus.o_instr_ready = instr_ready;
  assign bus.o_wr_valid    = wr_valid_q;
  assign bus.o_wr_addr     = wr_addr_q;
  assign bus.o_wr_data     = wr_data_q;
  assign bus.o_wr_strb     = wr_strb_q;
  assign bus.o_next_pc     = cur_q;
  assign bus.o_busy        = (state_q != StIdle) || wr_valid_q;

  // A buffered low half only exists while the cursor points at the upper half.
  pend_implies_odd_half: assert property (@(posedge i_clk) disable iff (i_rst)
    pend_valid_q |-> cur_q[1]);

endmodule

// File: tb/tb_instruction_packer.sv
// Scoreboard bench for instruction_packer: a parcel-level memory model predicts writes,
// a monitor pops and compares on every write handshake.
module tb_instruction_packer;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_packer_if #(.ADDR_WIDTH(AW)) bus ();
  instruction_packer #(.ADDR_WIDTH(AW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_count = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  // Reference model: where the next parcel goes, and a low half awaiting its partner.
  logic [31:0] m_cur = '0;
  bit          m_lo_valid = 0;
  logic [15:0] m_lo = '0;
  bit          m_active = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void place_parcel(input logic [31:0] a, input logic [15:0] p);
    wr_t w;
    if (!a[1]) begin
      m_lo = p;
      m_lo_valid = 1;
    end else begin
      w.addr = a & ~32'h3;
      w.data = {p, (m_lo_valid ? m_lo : 16'h0000)};
      w.strb = m_lo_valid ? 4'hF : 4'hC;
      exp_q.push_back(w);
      m_lo_valid = 0;
    end
  endfunction

  function automatic void model_accept(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) begin
      place_parcel(m_cur, ins[15:0]);
      m_cur = m_cur + 2;
    end else begin
      place_parcel(m_cur, ins[15:0]);
      place_parcel(m_cur + 2, ins[31:16]);
      m_cur = m_cur + 4;
    end
  endfunction

  function automatic void model_flush();
    wr_t w;
    if (!m_active) return;
    if (m_lo_valid) begin
      w.addr = m_cur & ~32'h3;
`ifdef INSTR_PACKER_NOP_PAD_EN
      w.data = {16'h0001, m_lo};
      w.strb = 4'hF;
`else
      w.data = {16'h0000, m_lo};
      w.strb = 4'h3;
`endif
      exp_q.push_back(w);
      m_lo_valid = 0;
    end
    m_active = 0;
  endfunction

  // Write-ready driver.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.i_wr_ready = 1'b1;
      1:       bus.i_wr_ready = ($urandom_range(0, 3) != 0);
      default: bus.i_wr_ready = 1'b0;
    endcase
  end

  // Monitor: a handshake visible at the negedge completes on the next posedge.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (!rst && bus.o_wr_valid && bus.i_wr_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.o_wr_addr, bus.o_wr_data, bus.o_wr_strb, 28'h0}, 96'h0);
      end else begin
        e = exp_q.pop_front();
        check("write", {28'h0, bus.o_wr_addr, bus.o_wr_data, bus.o_wr_strb},
              {28'h0, e.addr, e.data, e.strb});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic start(input logic [31:0] a);
    bus.i_start_valid = 1'b1;
    bus.i_start_addr  = a;
    @(posedge clk);
    #1;
    bus.i_start_valid = 1'b0;
    if (!m_active) begin
      m_cur = a & ~32'h1;
      m_lo_valid = 0;
      m_active = 1;
    end
    check("next_pc_after_start", bus.o_next_pc, m_cur);
  endtask

  task automatic push(input logic [31:0] ins, output int waits);
    bit acc = 0;
    waits = 0;
    bus.i_instr = ins;
    bus.i_instr_valid = 1'b1;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = bus.o_instr_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    bus.i_instr_valid = 1'b0;
    check("instr_accept", acc, 1);
    if (acc) model_accept(ins);
    check("next_pc", bus.o_next_pc, m_cur);
  endtask

  task automatic flush();
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    model_flush();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.o_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.o_busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_wr_valid", bus.o_wr_valid, 0);
    check("rst_wr_addr", bus.o_wr_addr, 0);
    check("rst_wr_data", bus.o_wr_data, 0);
    check("rst_wr_strb", bus.o_wr_strb, 0);
    check("rst_instr_ready", bus.o_instr_ready, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_next_pc", bus.o_next_pc, 0);
  endtask

  initial begin
    int w;
    logic [31:0] ha, hd;
    logic [3:0]  hs;
    int h0;

    rst = 1'b1;
    bus.i_start_valid = 0; bus.i_start_addr = '0; bus.i_instr_valid = 0;
    bus.i_instr = '0; bus.i_flush = 0; bus.i_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two compressed into one word.
    start(32'h1000);
    push(32'h0000_4501, w);
    push(32'h0000_4585, w);
    check("t1_next_pc", bus.o_next_pc, 32'h1004);
    flush();
    wait_idle("t1_idle");

    // 32-bit instruction spanning two words.
    start(32'h1000);
    push(32'h0000_0001, w);
    push(32'h00A0_0513, w);
    push(32'h0000_0001, w);
    check("t2_next_pc", bus.o_next_pc, 32'h1008);
    flush();
    wait_idle("t2_idle");

    // Odd start address.
    start(32'h1002);
    push(32'h0000_4501, w);
    flush();
    wait_idle("t3_idle");

    // Flush with a pending half, and flush while idle is ignored.
    start(32'h2000);
    push(32'h0000_4501, w);
    flush();
    wait_idle("flush_busy_low");
    flush();
    check("idle_flush_pc", bus.o_next_pc, 32'h2002);
    check("idle_flush_busy", bus.o_busy, 0);

    // Backpressure: held write must stay stable and block new instructions.
    rdy_mode = 2;
    bus.i_wr_ready = 1'b0;
    start(32'h4000);
    push(32'h0000_4501, w);
    push(32'h0000_4585, w);
    @(negedge clk);
    ha = bus.o_wr_addr; hd = bus.o_wr_data; hs = bus.o_wr_strb;
    bus.i_instr = 32'h0000_0001;
    bus.i_instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_wr_valid", bus.o_wr_valid, 1);
      check("bp_instr_ready", bus.o_instr_ready, 0);
      check("bp_stable", {bus.o_wr_addr, bus.o_wr_data, bus.o_wr_strb}, {ha, hd, hs});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.i_instr_valid = 1'b0;
    rdy_mode = 0;
    bus.i_wr_ready = 1'b1;
    h0 = hs_count;
    for (int i = 0; i < 4; i++) begin
      push({$urandom_range(0, 16'hFFFF), 14'h1555, 2'b11}, w);
      check("b2b_no_stall", w, 1);
    end
    @(negedge clk);
    #1;
    check("b2b_one_per_cycle", hs_count - h0, 5);
    @(posedge clk);
    #1;
    flush();
    wait_idle("bp_idle");

    // Reset mid-operation discards the pending half.
    start(32'h3000);
    push(32'h0000_4501, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outs();
    m_cur = '0; m_lo_valid = 0; m_active = 0;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Randomized streams with random backpressure, including address wrap.
    rdy_mode = 1;
    for (int s = 0; s < 25; s++) begin
      logic [31:0] a, ins;
      int n;
      a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      start(a);
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        ins = $urandom;
        if ($urandom_range(0, 1) == 1) ins[1:0] = 2'b11;
        else ins[1:0] = 2'($urandom_range(0, 2));
        push(ins, w);
        if ($urandom_range(0, 7) == 0) start($urandom);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      flush();
      wait_idle("rand_idle");
    end

    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
